// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module  : id_stage_pipe
// Purpose : Decode stage with register file, hazard stall, in-stage branch
//           resolution and a registered ID/EX boundary. Optional FWD_EN macro
//           enables EXE/MEM operand forwarding (load-use stalls only).
// Rev     : 1.0
// ============================================================================
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int RA_W   = $clog2(REG_N),
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       instruction,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exe_wb_en,
  input  logic              mem_wb_en,
  input  logic [RA_W-1:0]   exe_dest,
  input  logic [RA_W-1:0]   mem_dest,
  input  logic              exe_mem_r_en,
  input  logic [DATA_W-1:0] exe_fwd_data,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              freeze,
  output logic              stall,
  output logic              flush,
  output logic [IMM_W-1:0]  br_offset,
  output logic              idex_valid,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [DATA_W-1:0] reg2,
  output logic [RA_W-1:0]   dest,
  output logic [3:0]        exe_cmd,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en_out
);

  typedef enum logic [2:0] {K_NOP, K_R, K_I, K_LD, K_ST, K_BEZ, K_BNE, K_JMP} kind_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] r2;
    logic [RA_W-1:0]   dst;
    logic [3:0]        cmd;
    logic              mr;
    logic              mw;
    logic              wb;
  } idex_t;

  logic [DATA_W-1:0] rf_q [REG_N];
  idex_t             idex_q, idex_d;

  logic [5:0]        opcode;
  logic [RA_W-1:0]   dst_a, src1_a, src2_a;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_ext;
  kind_e             kind;
  logic [3:0]        cmd;
  logic              use_s1, use_s2, use_d, use_imm;
  logic [DATA_W-1:0] src1_rf, src2_rf, dst_rf;
  logic [DATA_W-1:0] op1, op2, opd;
  logic              hazard, br_taken;

  assign opcode  = instruction[31:26];
  assign dst_a   = instruction[21 +: RA_W];
  assign src1_a  = instruction[16 +: RA_W];
  assign src2_a  = instruction[11 +: RA_W];
  assign imm     = instruction[IMM_W-1:0];
  assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    kind = K_NOP;
    cmd  = 4'b0000;
    case (opcode)
      6'd1:        begin kind = K_R;  cmd = 4'b0000; end
      6'd3:        begin kind = K_R;  cmd = 4'b0010; end
      6'd5:        begin kind = K_R;  cmd = 4'b0100; end
      6'd6:        begin kind = K_R;  cmd = 4'b0101; end
      6'd7:        begin kind = K_R;  cmd = 4'b0110; end
      6'd8:        begin kind = K_R;  cmd = 4'b0111; end
      6'd9, 6'd10: begin kind = K_R;  cmd = 4'b1000; end
      6'd11:       begin kind = K_R;  cmd = 4'b1001; end
      6'd12:       begin kind = K_R;  cmd = 4'b1010; end
      6'd32:       begin kind = K_I;  cmd = 4'b0000; end
      6'd33:       begin kind = K_I;  cmd = 4'b0010; end
      6'd36:       kind = K_LD;
      6'd37:       kind = K_ST;
      6'd40:       kind = K_BEZ;
      6'd41:       kind = K_BNE;
      6'd42:       kind = K_JMP;
      default:     kind = K_NOP;
    endcase
  end

  assign use_s1  = (kind == K_R) || (kind == K_I) || (kind == K_LD) ||
                   (kind == K_ST) || (kind == K_BEZ) || (kind == K_BNE);
  assign use_s2  = (kind == K_R);
  assign use_d   = (kind == K_ST) || (kind == K_BNE);
  assign use_imm = (kind == K_I) || (kind == K_LD) || (kind == K_ST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_dest != '0)) begin
      rf_q[wb_dest] <= wb_data;
    end
  end

  // Same-cycle writeback is visible to the read (write-through bypass).
  assign src1_rf = (src1_a == '0) ? '0 : (wb_en && wb_dest == src1_a) ? wb_data : rf_q[src1_a];
  assign src2_rf = (src2_a == '0) ? '0 : (wb_en && wb_dest == src2_a) ? wb_data : rf_q[src2_a];
  assign dst_rf  = (dst_a  == '0) ? '0 : (wb_en && wb_dest == dst_a)  ? wb_data : rf_q[dst_a];

  function automatic logic hit(input logic [RA_W-1:0] a, input logic en,
                               input logic [RA_W-1:0] d);
    return en && (a != '0) && (a == d);
  endfunction

`ifdef FWD_EN
  assign op1 = hit(src1_a, exe_wb_en, exe_dest) ? exe_fwd_data :
               hit(src1_a, mem_wb_en, mem_dest) ? mem_fwd_data : src1_rf;
  assign op2 = hit(src2_a, exe_wb_en, exe_dest) ? exe_fwd_data :
               hit(src2_a, mem_wb_en, mem_dest) ? mem_fwd_data : src2_rf;
  assign opd = hit(dst_a, exe_wb_en, exe_dest) ? exe_fwd_data :
               hit(dst_a, mem_wb_en, mem_dest) ? mem_fwd_data : dst_rf;
  assign hazard = if_valid &&
                  ((use_s1 && hit(src1_a, exe_mem_r_en, exe_dest)) ||
                   (use_s2 && hit(src2_a, exe_mem_r_en, exe_dest)) ||
                   (use_d  && hit(dst_a,  exe_mem_r_en, exe_dest)));
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{exe_fwd_data, mem_fwd_data, exe_mem_r_en};
  assign op1 = src1_rf;
  assign op2 = src2_rf;
  assign opd = dst_rf;
  assign hazard = if_valid &&
                  ((use_s1 && (hit(src1_a, exe_wb_en, exe_dest) || hit(src1_a, mem_wb_en, mem_dest))) ||
                   (use_s2 && (hit(src2_a, exe_wb_en, exe_dest) || hit(src2_a, mem_wb_en, mem_dest))) ||
                   (use_d  && (hit(dst_a,  exe_wb_en, exe_dest) || hit(dst_a,  mem_wb_en, mem_dest))));
`endif

  assign br_taken  = ((kind == K_BEZ) && (op1 == '0)) ||
                     ((kind == K_BNE) && (op1 != opd)) ||
                     (kind == K_JMP);
  assign stall     = freeze || hazard;
  assign flush     = br_taken && if_valid && !stall;
  assign br_offset = imm;

  always_comb begin
    idex_d = idex_q;
    if (!freeze) begin
      idex_d = '0;
      if (if_valid && !hazard) begin
        idex_d.valid = 1'b1;
        idex_d.v1    = op1;
        idex_d.v2    = use_imm ? imm_ext : op2;
        idex_d.r2    = (kind == K_ST) ? opd : '0;
        idex_d.dst   = dst_a;
        idex_d.cmd   = cmd;
        idex_d.mr    = (kind == K_LD);
        idex_d.mw    = (kind == K_ST);
        idex_d.wb    = (kind == K_R) || (kind == K_I) || (kind == K_LD);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign idex_valid = idex_q.valid;
  assign val1       = idex_q.v1;
  assign val2       = idex_q.v2;
  assign reg2       = idex_q.r2;
  assign dest       = idex_q.dst;
  assign exe_cmd    = idex_q.cmd;
  assign mem_r_en   = idex_q.mr;
  assign mem_w_en   = idex_q.mw;
  assign wb_en_out  = idex_q.wb;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_stage_pipe
// Purpose : Randomized scoreboard bench for id_stage_pipe with a reference
//           model of decode, register file, hazards and branches.
// Rev     : 1.0
// ============================================================================
module tb_id_stage_pipe;

  localparam int KN = 0, KR = 1, KI = 2, KL = 3, KS = 4, KZ = 5, KB = 6, KJ = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid, wb_en, exe_wb_en, mem_wb_en, exe_mem_r_en, freeze;
  logic [31:0] instruction, wb_data, exe_fwd_data, mem_fwd_data;
  logic [4:0]  wb_dest, exe_dest, mem_dest;
  logic        stall, flush, idex_valid, mem_r_en, mem_w_en, wb_en_out;
  logic [15:0] br_offset;
  logic [31:0] val1, val2, reg2;
  logic [4:0]  dest;
  logic [3:0]  exe_cmd;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_mem_r_en(exe_mem_r_en), .exe_fwd_data(exe_fwd_data), .mem_fwd_data(mem_fwd_data),
    .freeze(freeze), .stall(stall), .flush(flush), .br_offset(br_offset),
    .idex_valid(idex_valid), .val1(val1), .val2(val2), .reg2(reg2), .dest(dest),
    .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en_out(wb_en_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [3:0]  cmd;
    logic        mr, mw, wb;
    logic [31:0] v1, v2, r2;
    logic [4:0]  d;
    logic        c1, c2, cr, cd;
  } exp_t;

  exp_t        q[$];
  exp_t        prev;
  logic [31:0] rf_m [32];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic [5:0] op);
    case (op)
      6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12: return KR;
      6'd32, 6'd33: return KI;
      6'd36:        return KL;
      6'd37:        return KS;
      6'd40:        return KZ;
      6'd41:        return KB;
      6'd42:        return KJ;
      default:      return KN;
    endcase
  endfunction

  function automatic logic [3:0] cmd_of(input logic [5:0] op);
    case (op)
      6'd3, 6'd33:  return 4'b0010;
      6'd5:         return 4'b0100;
      6'd6:         return 4'b0101;
      6'd7:         return 4'b0110;
      6'd8:         return 4'b0111;
      6'd9, 6'd10:  return 4'b1000;
      6'd11:        return 4'b1001;
      6'd12:        return 4'b1010;
      default:      return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] fv(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef FWD_EN
    if (exe_wb_en && exe_dest == a) return exe_fwd_data;
    if (mem_wb_en && mem_dest == a) return mem_fwd_data;
`endif
    if (wb_en && wb_dest == a) return wb_data;
    return rf_m[a];
  endfunction

  function automatic logic blocks(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef FWD_EN
    return exe_mem_r_en && exe_dest == a;
`else
    return (exe_wb_en && exe_dest == a) || (mem_wb_en && mem_dest == a);
`endif
  endfunction

  task automatic idle();
    if_valid = 0; instruction = 0; wb_en = 0; wb_dest = 0; wb_data = 0;
    exe_wb_en = 0; mem_wb_en = 0; exe_dest = 0; mem_dest = 0; exe_mem_r_en = 0;
    exe_fwd_data = 0; mem_fwd_data = 0; freeze = 0;
  endtask

  task automatic set_ins(input int op, input int d, input int s1, input int s2, input logic [15:0] im);
    if_valid    = 1;
    instruction = {6'(op), 5'(d), 5'(s1), 5'(s2), im};
  endtask

  // One clock: check combinational outputs, predict ID/EX contents after the edge.
  task automatic cycle();
    exp_t        e;
    int          k;
    logic [4:0]  s1, s2, d;
    logic [31:0] a1, a2, ad, sx;
    logic        hz, st, tk, fl;
    #1;
    k  = kind_of(instruction[31:26]);
    d  = instruction[25:21];
    s1 = instruction[20:16];
    s2 = instruction[15:11];
    sx = {{16{instruction[15]}}, instruction[15:0]};
    a1 = fv(s1); a2 = fv(s2); ad = fv(d);
    hz = if_valid && ((k inside {KR, KI, KL, KS, KZ, KB} && blocks(s1)) ||
                      (k == KR && blocks(s2)) ||
                      (k inside {KS, KB} && blocks(d)));
    st = freeze || hz;
    tk = (k == KZ && a1 == 0) || (k == KB && a1 != ad) || (k == KJ);
    fl = tk && if_valid && !st;
    chk("stall", 32'(stall), 32'(st));
    chk("flush", 32'(flush), 32'(fl));
    if (fl) chk("br_offset", 32'(br_offset), 32'(instruction[15:0]));
    e = '0;
    if (freeze) e = prev;
    else if (if_valid && !hz) begin
      e.v   = 1;
      e.cmd = cmd_of(instruction[31:26]);
      e.mr  = (k == KL);
      e.mw  = (k == KS);
      e.wb  = k inside {KR, KI, KL};
      e.c1  = k inside {KR, KI, KL, KS};
      e.c2  = e.c1;
      e.cr  = (k == KS);
      e.cd  = k inside {KR, KI, KL, KS};
      e.v1  = a1;
      e.v2  = (k == KR) ? a2 : sx;
      e.r2  = ad;
      e.d   = d;
    end
    prev = e;
    q.push_back(e);
    if (wb_en && wb_dest != 0) rf_m[wb_dest] = wb_data;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    exp_t z;
    z = '0; z.c1 = 1; z.c2 = 1; z.cr = 1; z.cd = 1;
    idle();
    rst = 0;
    #1;
    chk("rst_idex_valid", 32'(idex_valid), 0);
    chk("rst_val1", val1, 0);
    chk("rst_val2", val2, 0);
    chk("rst_dest", 32'(dest), 0);
    chk("rst_ctrl", 32'({mem_r_en, mem_w_en, wb_en_out, exe_cmd}), 0);
    for (int i = 0; i < 32; i++) rf_m[i] = 0;
    prev = z;
    repeat (n) begin
      q.push_back(z);
      @(negedge clk);
    end
    rst = 1;
  endtask

  task automatic rand_cycle();
    int ops[17] = '{1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};
    int op;
    idle();
    op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 16)];
    set_ins(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
    if_valid     = ($urandom_range(0, 7) != 0);
    wb_en        = $urandom_range(0, 1) == 1;
    wb_dest      = 5'($urandom_range(0, 7));
    wb_data      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    exe_wb_en    = $urandom_range(0, 2) == 0;
    mem_wb_en    = $urandom_range(0, 2) == 0;
    exe_dest     = 5'($urandom_range(0, 7));
    mem_dest     = 5'($urandom_range(0, 7));
    exe_mem_r_en = $urandom_range(0, 3) == 0;
    exe_fwd_data = $urandom;
    mem_fwd_data = $urandom;
    freeze       = $urandom_range(0, 9) == 0;
    cycle();
  endtask

  // Scoreboard monitor: compares registered outputs one cycle after issue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("idex_valid", 32'(idex_valid), 32'(e.v));
        chk("exe_cmd", 32'(exe_cmd), 32'(e.cmd));
        chk("mem_r_en", 32'(mem_r_en), 32'(e.mr));
        chk("mem_w_en", 32'(mem_w_en), 32'(e.mw));
        chk("wb_en_out", 32'(wb_en_out), 32'(e.wb));
        if (e.c1) chk("val1", val1, e.v1);
        if (e.c2) chk("val2", val2, e.v2);
        if (e.cr) chk("reg2", reg2, e.r2);
        if (e.cd) chk("dest", 32'(dest), 32'(e.d));
      end
    end
  end

  initial begin
    idle();
    prev = '0;
    @(negedge clk);
    do_reset(2);
    for (int i = 0; i < 100; i++) rand_cycle();
    do_reset(2);

    idle(); wb_en = 1; wb_dest = 1; wb_data = 32'd7; cycle();
    idle(); set_ins(32, 2, 1, 0, 16'd5); cycle();
    idle(); set_ins(1, 3, 2, 2, 16'h0); exe_dest = 2; exe_wb_en = 1; exe_fwd_data = 32'h10; cycle();
    exe_mem_r_en = 1; cycle();
    idle(); set_ins(1, 3, 2, 2, 16'h0); cycle();
    idle(); wb_en = 1; wb_dest = 4; wb_data = 32'h0; cycle();
    idle(); set_ins(40, 0, 4, 0, 16'hFFFE); cycle();
    idle(); wb_en = 1; wb_dest = 4; wb_data = 32'h1; cycle();
    idle(); set_ins(40, 0, 4, 0, 16'hFFFE); cycle();
    idle(); set_ins(1, 6, 5, 0, 16'h0); wb_en = 1; wb_dest = 5; wb_data = 32'hAB; cycle();
    idle(); wb_en = 1; wb_dest = 0; wb_data = 32'h55; set_ins(1, 7, 0, 0, 16'h0); cycle();
    idle(); set_ins(1, 7, 0, 0, 16'h0); cycle();
    idle(); set_ins(37, 5, 1, 0, 16'h8004); cycle();
    idle(); set_ins(42, 0, 0, 0, 16'h0010); freeze = 1;
    repeat (3) cycle();
    freeze = 0; cycle();

    for (int i = 0; i < 300; i++) rand_cycle();
    idle();
    cycle();
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
